// File: rtl/apb_master_arbiter_if.sv
// apb_master_arbiter_if: requester handshakes and APB bus shared by the arbiter and its environment
interface apb_master_arbiter_if;
    logic       req0_valid, req0_write, req0_ready, req0_done, req0_err;
    logic [7:0] req0_addr, req0_wdata, req0_rdata;
    logic       req1_valid, req1_write, req1_ready, req1_done, req1_err;
    logic [7:0] req1_addr, req1_wdata, req1_rdata;
    logic       psel, penable, pwrite, pready;
    logic [7:0] paddr, pwdata_in, prdata_out;
    modport master (
        input  req0_valid, req0_write, req0_addr, req0_wdata,
        output req0_ready, req0_done, req0_err, req0_rdata,
        input  req1_valid, req1_write, req1_addr, req1_wdata,
        output req1_ready, req1_done, req1_err, req1_rdata,
        output psel, penable, pwrite, paddr, pwdata_in,
        input  prdata_out, pready
    );
    modport slave (
        output req0_valid, req0_write, req0_addr, req0_wdata,
        input  req0_ready, req0_done, req0_err, req0_rdata,
        output req1_valid, req1_write, req1_addr, req1_wdata,
        input  req1_ready, req1_done, req1_err, req1_rdata,
        input  psel, penable, pwrite, paddr, pwdata_in,
        output prdata_out, pready
    );
endinterface

// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter: two-requester round-robin arbiter driving a single APB master port with ACCESS timeout
module apb_master_arbiter #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 presetn,
    apb_master_arbiter_if.master bus
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
    state_t     state, state_n;
    logic       last_g, g, gnt_any, gnt_id, finish, abort, wr_n;
    logic [7:0] cnt;
    always_comb begin
        gnt_any        = bus.req0_valid | bus.req1_valid;
        gnt_id         = (bus.req0_valid & bus.req1_valid) ? ~last_g : bus.req1_valid;
        wr_n           = gnt_id ? bus.req1_write : bus.req0_write;
        finish         = (state == ACCESS) & bus.pready;
        // pready on the final counted cycle still completes normally
        abort          = (state == ACCESS) & ~bus.pready & (cnt == 8'(TIMEOUT_CYCLES - 1));
        bus.req0_ready = (state == IDLE) & gnt_any & ~gnt_id;
        bus.req1_ready = (state == IDLE) & gnt_any & gnt_id;
        state_n        = (state == IDLE)  ? (gnt_any ? SETUP : IDLE) :
                         (state == SETUP) ? ACCESS :
                         (finish | abort) ? IDLE : ACCESS;
    end
    always_ff @(posedge clk) begin
        if (!presetn) state <= IDLE;
        else          state <= state_n;
    end
    always_ff @(posedge clk) begin
        if (!presetn) begin
            last_g         <= 1'b1;
            g              <= 1'b0;
            cnt            <= 8'h00;
            bus.psel       <= 1'b0;
            bus.penable    <= 1'b0;
            bus.pwrite     <= 1'b0;
            bus.paddr      <= 8'h00;
            bus.pwdata_in  <= 8'h00;
            bus.req0_done  <= 1'b0;
            bus.req1_done  <= 1'b0;
            bus.req0_err   <= 1'b0;
            bus.req1_err   <= 1'b0;
            bus.req0_rdata <= 8'h00;
            bus.req1_rdata <= 8'h00;
        end else begin
            cnt           <= (state == ACCESS && !bus.pready) ? cnt + 8'd1 : 8'h00;
            bus.psel      <= state_n != IDLE;
            bus.penable   <= state_n == ACCESS;
            bus.req0_done <= (finish | abort) & ~g;
            bus.req1_done <= (finish | abort) & g;
            bus.req0_err  <= abort & ~g;
            bus.req1_err  <= abort & g;
            if ((finish | abort) && !bus.pwrite && !g) bus.req0_rdata <= abort ? 8'h00 : bus.prdata_out;
            if ((finish | abort) && !bus.pwrite && g)  bus.req1_rdata <= abort ? 8'h00 : bus.prdata_out;
            if (state == IDLE && gnt_any) begin
                last_g        <= gnt_id;
                g             <= gnt_id;
                bus.pwrite    <= wr_n;
                bus.paddr     <= gnt_id ? bus.req1_addr : bus.req0_addr;
                bus.pwdata_in <= !wr_n ? 8'h00 : gnt_id ? bus.req1_wdata : bus.req0_wdata;
            end
        end
    end
endmodule

// File: tb/tb_apb_master_arbiter.sv
// tb_apb_master_arbiter: directed per-cycle vector table plus timeout and reset sequences
module tb_apb_master_arbiter;
    logic clk = 1'b0;
    logic presetn = 1'b0;
    int n_chk = 0;
    int n_fail = 0;
    apb_master_arbiter_if bus();
    apb_master_arbiter #(.TIMEOUT_CYCLES(16)) dut (.clk(clk), .presetn(presetn), .bus(bus));
    always #5 clk = ~clk;
    typedef struct {
        logic [3:0]  vw;
        logic [31:0] ad;
        logic        rdy;
        logic [7:0]  prd;
        logic [40:0] exp;
    } vec_t;
    vec_t tbl[$];
    function automatic logic [40:0] outs();
        return {bus.req1_ready, bus.req0_ready, bus.psel, bus.penable, bus.pwrite, bus.paddr,
                bus.pwdata_in, bus.req1_done, bus.req0_done, bus.req1_err, bus.req0_err,
                bus.req0_rdata, bus.req1_rdata};
    endfunction
    // vw={v0,v1,w0,w1} ad={a0,a1,d0,d1} ry={r1,r0} ctl={psel,penable,pwrite} de={done1,done0,err1,err0} rd={rdata0,rdata1}
    task automatic add(input logic [3:0] vw, input logic [31:0] ad, input logic rdy, input logic [7:0] prd,
                       input logic [1:0] ry, input logic [2:0] ctl, input logic [15:0] pa_pwd,
                       input logic [3:0] de, input logic [15:0] rd);
        vec_t v;
        v.vw = vw; v.ad = ad; v.rdy = rdy; v.prd = prd;
        v.exp = {ry, ctl, pa_pwd, de, rd};
        tbl.push_back(v);
    endtask
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic next();
        @(posedge clk);
        #1;
    endtask
    task automatic settle();
        #3;
    endtask
    task automatic timeout_run(input logic late);
        int n = 0;
        next();
        bus.req0_valid = 1'b1; bus.req0_write = 1'b0; bus.req0_addr = 8'h55;
        bus.pready = 1'b0; bus.prdata_out = 8'h9A;
        settle();
        chk("to_accept", {bus.req1_ready, bus.req0_ready}, 2'b01);
        next();
        bus.req0_valid = 1'b0;
        settle();
        chk("to_setup", {bus.psel, bus.penable}, 2'b10);
        for (int k = 1; k <= 16; k++) begin
            next();
            bus.pready = late && k == 16;
            settle();
            if (bus.psel && bus.penable && !bus.req0_done) n++;
        end
        next();
        bus.pready = 1'b0;
        settle();
        chk("to_cycles", n, 16);
        chk("to_result", {bus.req1_done, bus.req0_done, bus.req0_err, bus.psel, bus.penable, bus.req0_rdata},
            {1'b0, 1'b1, !late, 1'b0, 1'b0, late ? 8'h9A : 8'h00});
    endtask
    initial begin
        bus.req0_valid = 0; bus.req0_write = 0; bus.req0_addr = 0; bus.req0_wdata = 0;
        bus.req1_valid = 0; bus.req1_write = 0; bus.req1_addr = 0; bus.req1_wdata = 0;
        bus.pready = 0; bus.prdata_out = 0;
        add(4'b0000, 32'h00000000, 0, 8'h00, 2'b00, 3'b000, 16'h0000, 4'b0000, 16'h0000);
        add(4'b1010, 32'h1000A500, 0, 8'h00, 2'b01, 3'b000, 16'h0000, 4'b0000, 16'h0000);
        add(4'b0000, 32'h00000000, 1, 8'h00, 2'b00, 3'b101, 16'h10A5, 4'b0000, 16'h0000);
        add(4'b0000, 32'h00000000, 1, 8'h00, 2'b00, 3'b111, 16'h10A5, 4'b0000, 16'h0000);
        add(4'b0000, 32'h00000000, 0, 8'hFF, 2'b00, 3'b001, 16'h10A5, 4'b0100, 16'h0000);
        add(4'b0100, 32'h00220077, 0, 8'h00, 2'b10, 3'b001, 16'h10A5, 4'b0000, 16'h0000);
        add(4'b0000, 32'h00000000, 0, 8'h00, 2'b00, 3'b100, 16'h2200, 4'b0000, 16'h0000);
        add(4'b0000, 32'h00000000, 0, 8'h00, 2'b00, 3'b110, 16'h2200, 4'b0000, 16'h0000);
        add(4'b0000, 32'h00000000, 0, 8'h00, 2'b00, 3'b110, 16'h2200, 4'b0000, 16'h0000);
        add(4'b0000, 32'h00000000, 0, 8'h00, 2'b00, 3'b110, 16'h2200, 4'b0000, 16'h0000);
        add(4'b0000, 32'h00000000, 1, 8'h5C, 2'b00, 3'b110, 16'h2200, 4'b0000, 16'h0000);
        add(4'b0000, 32'h00000000, 0, 8'h00, 2'b00, 3'b000, 16'h2200, 4'b1000, 16'h005C);
        add(4'b1111, 32'h30401122, 1, 8'h00, 2'b01, 3'b000, 16'h2200, 4'b0000, 16'h005C);
        add(4'b1111, 32'h30401122, 1, 8'h00, 2'b00, 3'b101, 16'h3011, 4'b0000, 16'h005C);
        add(4'b1111, 32'h30401122, 1, 8'h00, 2'b00, 3'b111, 16'h3011, 4'b0000, 16'h005C);
        add(4'b1111, 32'h30401122, 1, 8'h00, 2'b10, 3'b001, 16'h3011, 4'b0100, 16'h005C);
        add(4'b1111, 32'h30401122, 1, 8'h00, 2'b00, 3'b101, 16'h4022, 4'b0000, 16'h005C);
        add(4'b1111, 32'h30401122, 1, 8'h00, 2'b00, 3'b111, 16'h4022, 4'b0000, 16'h005C);
        add(4'b1111, 32'h30401122, 1, 8'h00, 2'b01, 3'b001, 16'h4022, 4'b1000, 16'h005C);
        add(4'b1111, 32'h30401122, 1, 8'h00, 2'b00, 3'b101, 16'h3011, 4'b0000, 16'h005C);
        add(4'b1111, 32'h30401122, 1, 8'h00, 2'b00, 3'b111, 16'h3011, 4'b0000, 16'h005C);
        add(4'b1111, 32'h30401122, 1, 8'h00, 2'b10, 3'b001, 16'h3011, 4'b0100, 16'h005C);
        add(4'b1111, 32'h30401122, 1, 8'h00, 2'b00, 3'b101, 16'h4022, 4'b0000, 16'h005C);
        add(4'b1111, 32'h30401122, 1, 8'h00, 2'b00, 3'b111, 16'h4022, 4'b0000, 16'h005C);
        add(4'b0000, 32'h00000000, 0, 8'h00, 2'b00, 3'b001, 16'h4022, 4'b1000, 16'h005C);
        repeat (2) @(posedge clk);
        #1 presetn = 1'b1;
        settle();
        chk("reset", outs(), 41'h0);
        foreach (tbl[i]) begin
            next();
            {bus.req0_valid, bus.req1_valid, bus.req0_write, bus.req1_write} = tbl[i].vw;
            {bus.req0_addr, bus.req1_addr, bus.req0_wdata, bus.req1_wdata} = tbl[i].ad;
            bus.pready = tbl[i].rdy;
            bus.prdata_out = tbl[i].prd;
            settle();
            chk($sformatf("row%0d", i), outs(), tbl[i].exp);
        end
        timeout_run(1'b1);
        timeout_run(1'b0);
        next();
        bus.req0_valid = 1'b1; bus.req0_write = 1'b1; bus.req0_addr = 8'h66; bus.req0_wdata = 8'hEE;
        settle();
        chk("rst_accept", {bus.req1_ready, bus.req0_ready}, 2'b01);
        next();
        bus.req0_valid = 1'b0;
        next();
        settle();
        chk("rst_access", {bus.psel, bus.penable}, 2'b11);
        presetn = 1'b0;
        bus.pready = 1'b1;
        next();
        presetn = 1'b1;
        bus.pready = 1'b0;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        settle();
        chk("rst_abort", {bus.psel, bus.penable, bus.pwrite, bus.paddr, bus.req1_done, bus.req0_done}, 0);
        chk("rst_tie", {bus.req1_ready, bus.req0_ready}, 2'b01);
        next();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        settle();
        chk("rst_setup", {bus.psel, bus.penable, bus.paddr, bus.pwdata_in}, {2'b10, 8'h66, 8'hEE});
        next();
        bus.pready = 1'b1;
        next();
        bus.pready = 1'b0;
        settle();
        chk("rst_done", {bus.req1_done, bus.req0_done, bus.req0_err}, 3'b010);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
